// File: rtl/maxnet_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maxnet_pkg: shared defaults and loader state encoding for Maxnet     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package maxnet_pkg;

  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_DATA_W    = 16;
  localparam int VEC_CNT_W     = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } loader_state_t;

endpackage : maxnet_pkg
`default_nettype wire

// File: rtl/maxnet_input_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maxnet_input_loader_if: stream, memory-write and Maxnet control bus  |
// | Optional clamp_seen signal under MAXNET_NEG_CLAMP_EN. Rev 1.0        |
// +----------------------------------------------------------------------+
interface maxnet_input_loader_if
  import maxnet_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int AW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
);

  logic                 in_valid;
  logic [DATA_W-1:0]    in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 mem_wr_en;
  logic [AW-1:0]        mem_addr;
  logic [DATA_W-1:0]    mem_wr_data;
  logic                 mx_start;
  logic                 mx_ready;
  logic                 busy;
  logic                 err_len;
  logic [VEC_CNT_W-1:0] vec_count;
`ifdef MAXNET_NEG_CLAMP_EN
  logic                 clamp_seen;

  modport master (
    output in_valid, in_data, in_last, mx_ready,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data, mx_start,
           busy, err_len, vec_count, clamp_seen
  );

  modport slave (
    input  in_valid, in_data, in_last, mx_ready,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data, mx_start,
           busy, err_len, vec_count, clamp_seen
  );
`else
  modport master (
    output in_valid, in_data, in_last, mx_ready,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data, mx_start,
           busy, err_len, vec_count
  );

  modport slave (
    input  in_valid, in_data, in_last, mx_ready,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data, mx_start,
           busy, err_len, vec_count
  );
`endif

endinterface : maxnet_input_loader_if
`default_nettype wire

// File: rtl/maxnet_rise_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maxnet_rise_detect: rising-edge detect against the registered level  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module maxnet_rise_detect (
  input  wire  clk,
  input  wire  rst,
  input  wire  d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule : maxnet_rise_detect
`default_nettype wire

// File: rtl/maxnet_input_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maxnet_input_loader: loads one vector into Maxnet memory, starts it, |
// | waits for completion. Optional MAXNET_NEG_CLAMP_EN clamps negatives. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module maxnet_input_loader
  import maxnet_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int AW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input wire clk,
  input wire rst,
  maxnet_input_loader_if.slave bus
);

  loader_state_t        state_q;
  logic [AW-1:0]        idx_q;
  logic                 in_ready_q;
  logic                 mem_wr_en_q;
  logic [AW-1:0]        mem_addr_q;
  logic [DATA_W-1:0]    mem_wr_data_q;
  logic [DATA_W-1:0]    mem_wr_data_d;
  logic                 mx_start_q;
  logic                 busy_q;
  logic                 err_len_q;
  logic [VEC_CNT_W-1:0] vec_count_q;

  logic w_accept;
  logic w_last_pos;
  logic w_frame_err;
  logic w_mx_rise;

  maxnet_rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.mx_ready),
    .rise_o (w_mx_rise)
  );

  assign w_accept    = bus.in_valid & in_ready_q;
  assign w_last_pos  = (idx_q == AW'(N_NEURONS - 1));
  // Framing is wrong when in_last and the final index disagree in either direction.
  assign w_frame_err = bus.in_last ^ w_last_pos;

`ifdef MAXNET_NEG_CLAMP_EN
  logic w_neg;
  logic clamp_seen_q;

  assign w_neg         = bus.in_data[DATA_W-1];
  assign mem_wr_data_d = w_neg ? '0 : bus.in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clamp_seen_q <= 1'b0;
    end else if (w_accept) begin
      clamp_seen_q <= (idx_q == '0) ? w_neg : (clamp_seen_q | w_neg);
    end
  end

  assign bus.clamp_seen = clamp_seen_q;
`else
  assign mem_wr_data_d = bus.in_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= LOAD;
      idx_q         <= '0;
      in_ready_q    <= 1'b1;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_len_q     <= 1'b0;
      vec_count_q   <= '0;
    end else begin
      mem_wr_en_q <= 1'b0;
      err_len_q   <= 1'b0;
      mx_start_q  <= 1'b0;
      unique case (state_q)
        LOAD: begin
          if (w_accept) begin
            mem_wr_en_q   <= 1'b1;
            mem_addr_q    <= idx_q;
            mem_wr_data_q <= mem_wr_data_d;
            if (w_frame_err) begin
              err_len_q <= 1'b1;
              idx_q     <= '0;
              busy_q    <= 1'b0;
            end else if (w_last_pos) begin
              state_q    <= FLUSH;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              idx_q  <= idx_q + AW'(1);
              busy_q <= 1'b1;
            end
          end
        end
        FLUSH: begin
          state_q    <= START;
          mx_start_q <= 1'b1;
        end
        START: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (w_mx_rise) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            vec_count_q <= vec_count_q + VEC_CNT_W'(1);
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.mx_start    = mx_start_q;
  assign bus.busy        = busy_q;
  assign bus.err_len     = err_len_q;
  assign bus.vec_count   = vec_count_q;

endmodule : maxnet_input_loader
`default_nettype wire

// File: tb/tb_maxnet_input_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_maxnet_input_loader: directed bench with a cycle-level model      |
// | Expectations follow MAXNET_NEG_CLAMP_EN when defined. Rev 1.0        |
// +----------------------------------------------------------------------+
module tb_maxnet_input_loader;
  import maxnet_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maxnet_input_loader_if #(.N_NEURONS(N), .DATA_W(DW)) bus ();

  maxnet_input_loader #(.N_NEURONS(N), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;
  int cyc = 0;
  int last_beat_cyc = 0;

  // Model view: m_since is -1 while accepting words, otherwise the number
  // of cycles elapsed since the correctly framed final beat.
  bit m_ready = 1'b1, m_wr = 1'b0, m_start = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  bit m_prev = 1'b0, m_clamp = 1'b0;
  int m_addr = 0, m_data = 0, m_cnt = 0, m_n = 0, m_since = -1;

  int wa[$];
  int wd[$];
  int n_start = 0;
  int n_err = 0;
  int start_cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int proc(input logic signed [DW-1:0] d);
`ifdef MAXNET_NEG_CLAMP_EN
    return (d < 0) ? 0 : int'(d);
`else
    return int'(d);
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    logic signed [DW-1:0] d;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_ready = 1'b1; m_wr = 1'b0; m_start = 1'b0; m_busy = 1'b0; m_err = 1'b0;
      m_prev = 1'b0; m_clamp = 1'b0; m_addr = 0; m_data = 0; m_cnt = 0;
      m_n = 0; m_since = -1;
    end else begin
      m_wr = 1'b0; m_err = 1'b0; m_start = 1'b0;
      if (m_since < 0) begin
        if (bus.in_valid) begin
          d       = bus.in_data;
          m_wr    = 1'b1;
          m_addr  = m_n;
          m_data  = proc(d);
          m_clamp = ((m_n == 0) ? 1'b0 : m_clamp) | (d < 0);
          if (bus.in_last != (m_n == N - 1)) begin
            m_err = 1'b1;
            m_n   = 0;
          end else if (m_n == N - 1) begin
            m_since = 0;
          end else begin
            m_n++;
          end
        end
      end else begin
        if (m_since == 0) m_start = 1'b1;
        if (m_since >= 2 && bus.mx_ready && !m_prev) begin
          m_since = -1;
          m_n     = 0;
          m_cnt   = (m_cnt + 1) % 256;
        end else begin
          m_since++;
        end
      end
      m_prev  = bus.mx_ready;
      m_ready = (m_since < 0);
      m_busy  = (m_since >= 0) || (m_n != 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("in_ready", int'(bus.in_ready), int'(m_ready));
      chk("mem_wr_en", int'(bus.mem_wr_en), int'(m_wr));
      if (m_wr) begin
        chk("mem_addr", int'(bus.mem_addr), m_addr);
        chk("mem_wr_data", int'($signed(bus.mem_wr_data)), m_data);
      end
      chk("mx_start", int'(bus.mx_start), int'(m_start));
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("err_len", int'(bus.err_len), int'(m_err));
      chk("vec_count", int'(bus.vec_count), m_cnt);
`ifdef MAXNET_NEG_CLAMP_EN
      chk("clamp_seen", int'(bus.clamp_seen), int'(m_clamp));
`endif
    end
    if (bus.mem_wr_en === 1'b1) begin
      wa.push_back(int'(bus.mem_addr));
      wd.push_back(int'($signed(bus.mem_wr_data)));
    end
    if (bus.mx_start === 1'b1) begin
      n_start++;
      start_cyc = cyc;
    end
    if (bus.err_len === 1'b1) n_err++;
  end

  task automatic beat(input int d, input bit last);
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(d);
    bus.in_last   = last;
    last_beat_cyc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
    chk({tag, "_wr_en"}, int'(bus.mem_wr_en), 0);
    chk({tag, "_addr"}, int'(bus.mem_addr), 0);
    chk({tag, "_data"}, int'(bus.mem_wr_data), 0);
    chk({tag, "_start"}, int'(bus.mx_start), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_err"}, int'(bus.err_len), 0);
    chk({tag, "_vec"}, int'(bus.vec_count), 0);
  endtask

  task automatic complete_pulse(input int exp_cnt);
    bus.mx_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("done_in_ready", int'(bus.in_ready), 1);
    chk("done_vec_count", int'(bus.vec_count), exp_cnt);
    bus.mx_ready = 1'b0;
  endtask

  task automatic chk_writes(input string tag, input int base, input int exp_d[4]);
    chk({tag, "_nwr"}, wa.size() - base, 4);
    if (wa.size() - base == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_addr"}, wa[base + i], i);
        chk({tag, "_data"}, wd[base + i], exp_d[i]);
      end
    end
  endtask

  initial begin
    int base, s_start, s_err;
    int nom_d[4];
    int clamp_d[4];
    nom_d = '{10, 3, 7, 1};
`ifdef MAXNET_NEG_CLAMP_EN
    clamp_d = '{0, 4, 0, 2};
`else
    clamp_d = '{-5, 4, -1, 2};
`endif
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.mx_ready = 1'b0;

    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); check_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset_checks("rst0");
    @(negedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a vector
    beat(11, 0); beat(22, 0);
    #2 rst = 1'b0;
    @(negedge clk); #1 reset_checks("rst_mid");
    #1 rst = 1'b1;
    @(negedge clk);

    // Nominal vector
    base = wa.size(); s_start = n_start;
    beat(10, 0); beat(3, 0); beat(7, 0); beat(1, 1);
    repeat (4) @(negedge clk);
    #1;
    chk_writes("nom", base, nom_d);
    chk("nom_nstart", n_start - s_start, 1);
    chk("nom_start_lat", start_cyc - last_beat_cyc, 2);
    chk("nom_ready_low", int'(bus.in_ready), 0);
    chk("nom_busy", int'(bus.busy), 1);
    complete_pulse(1);
    @(negedge clk);

    // Early last on beat 1
    s_start = n_start; s_err = n_err;
    beat(5, 0); beat(6, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("early_err", n_err - s_err, 1);
    chk("early_nstart", n_start - s_start, 0);
    chk("early_ready", int'(bus.in_ready), 1);
    base = wa.size();
    beat(1, 0); beat(2, 0); beat(3, 0); beat(4, 1);
    repeat (4) @(negedge clk);
    #1;
    chk("early_next_addr0", (wa.size() > base) ? wa[base] : -1, 0);
    chk("early_next_nstart", n_start - s_start, 1);
    complete_pulse(2);
    @(negedge clk);

    // Missing last
    s_start = n_start; s_err = n_err;
    beat(9, 0); beat(8, 0); beat(7, 0); beat(6, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("miss_err", n_err - s_err, 1);
    chk("miss_nstart", n_start - s_start, 0);
    chk("miss_busy", int'(bus.busy), 0);
    chk("miss_ready", int'(bus.in_ready), 1);

    // Stale ready held through START
    bus.mx_ready = 1'b1;
    @(negedge clk);
    beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 1);
    repeat (6) @(negedge clk);
    #1;
    chk("stale_vec", int'(bus.vec_count), 2);
    chk("stale_ready", int'(bus.in_ready), 0);
    bus.mx_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("stale_vec_low", int'(bus.vec_count), 2);
    complete_pulse(3);
    @(negedge clk);

    // Negative words
    base = wa.size();
    beat(-5, 0); beat(4, 0); beat(-1, 0); beat(2, 1);
    repeat (3) @(negedge clk);
    #1;
    chk_writes("clamp", base, clamp_d);
`ifdef MAXNET_NEG_CLAMP_EN
    chk("clamp_seen", int'(bus.clamp_seen), 1);
`endif
    complete_pulse(4);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule : tb_maxnet_input_loader
`default_nettype wire
